// File: rtl/seq_pkg.sv
// Shared types and default sizes for the command sequence player.
//   seq_state_t : playback FSM states
//   seq_entry_t : one table entry {post-delay, command byte}
package seq_pkg;

    localparam int unsigned SEQ_DEPTH  = 8;
    localparam int unsigned SEQ_DATA_W = 8;
    localparam int unsigned SEQ_DLY_W  = 24;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        DELAY
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_DLY_W-1:0]  dly;
        logic [SEQ_DATA_W-1:0] cmd;
    } seq_entry_t;

endpackage

// File: rtl/cmd_seq_table.sv
// Command table: DEPTH x seq_entry_t register file, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk     : system clock
//   wr_en   : write strobe (already qualified by the caller)
//   wr_addr : entry to write
//   wr_data : entry contents
//   rd_addr : entry to read
//   rd_data : entry contents at rd_addr (combinational)
module cmd_seq_table
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  seq_entry_t       wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output seq_entry_t       rd_data
);

    seq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_seq_player.sv
// Timed command sequencer: plays table entries (command byte, post-delay)
// into a uart_tx through its trmt/tx_data/tx_done handshake.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_en/wr_addr/
//   wr_cmd/wr_dly      : table write port, honoured only while idle
//   num_cmds, loop_en  : entries to play and wrap mode, sampled at start
//   start, abort       : begin / stop playback
//   trmt, tx_data      : transmit pulse and byte to uart_tx
//   tx_done            : uart_tx completion, only its rising edge is used
//   busy, done, cur_idx: status, completion pulse, entry being played
//   wr_err             : pulse when a write arrives while busy (dropped)
module cmd_seq_player
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_DEPTH,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned DATA_W = SEQ_DATA_W,
    localparam int unsigned DLY_W  = SEQ_DLY_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_cmd,
    input  logic [DLY_W-1:0]  wr_dly,
    input  logic [IDX_W:0]    num_cmds,
    input  logic              loop_en,
    input  logic              start,
    input  logic              abort,
    output logic              trmt,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  cur_idx,
    output logic              wr_err
);

    seq_state_t        state_q, state_d;
    seq_entry_t        rd_entry;
    logic              tx_done_q;
    logic              tx_rise;
    logic              abort_q;
    logic              loop_q;
    logic              done_d;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W:0]    n_clamp;
    logic [DLY_W-1:0]  dly_rem_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              done_q;
    logic              wr_err_q;
    logic [IDX_W-1:0]  cur_idx_q;

    cmd_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk     (clk),
        .wr_en   (wr_en && (state_q == IDLE)),
        .wr_addr (wr_addr),
        .wr_data ({wr_dly, wr_cmd}),
        .rd_addr (cur_idx_q),
        .rd_data (rd_entry)
    );

    assign tx_rise = tx_done && !tx_done_q;

    always_comb begin
        n_clamp = (num_cmds > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_cmds;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done_d marks the transitions that end a sequence normally
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (num_cmds == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                state_d = abort ? IDLE : WAIT_DONE;
            end
            WAIT_DONE: begin
                // an abort seen at any point while waiting still lets the byte finish
                if (tx_rise) begin
                    state_d = (abort || abort_q) ? IDLE : DELAY;
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dly_rem_q <= DLY_W'(1)) begin
                    if ((cur_idx_q != last_q) || loop_q) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; tx_data is taken straight from the table during SEND so a
    // write landing on the start edge is already visible with trmt
    always_comb begin
        trmt    = (state_q == SEND);
        busy    = (state_q != IDLE);
        tx_data = (state_q == SEND) ? rd_entry.cmd : tx_data_q;
        done    = done_q;
        wr_err  = wr_err_q;
        cur_idx = cur_idx_q;
    end

    // Datapath: edge detect, index, delay counter, held byte, status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done_q <= 1'b0;
            abort_q   <= 1'b0;
            loop_q    <= 1'b0;
            last_q    <= '0;
            dly_rem_q <= '0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            cur_idx_q <= '0;
        end else begin
            tx_done_q <= tx_done;
            done_q    <= done_d;
            wr_err_q  <= wr_en && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (state_d == SEND) begin
                        cur_idx_q <= '0;
                        loop_q    <= loop_en;
                        last_q    <= IDX_W'(n_clamp - (IDX_W+1)'(1));
                    end
                end
                SEND: begin
                    tx_data_q <= rd_entry.cmd;
                end
                WAIT_DONE: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (tx_rise) begin
                        dly_rem_q <= rd_entry.dly;
                    end
                end
                DELAY: begin
                    if (dly_rem_q > DLY_W'(1)) begin
                        dly_rem_q <= dly_rem_q - DLY_W'(1);
                    end
                    if (state_d == SEND) begin
                        cur_idx_q <= (cur_idx_q == last_q) ? '0 : cur_idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
